fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID buffer directly upstream of the main decode controller.
- Holds the PC and issues one outstanding request at a time to instruction memory.
- Buffers the returned word and presents id_instr/id_opcode to decode, honouring decode stalls and execute-stage branch redirects.

Parameters:
PC_W, 9, byte-address width of PC and imem_addr.
INS_W, 32, instruction width.
RESET_PC, 0, PC value loaded at reset; must be 4-byte aligned.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request; held high until imem_rvalid.
imem_addr  out  PC_W  fetch address; stable while imem_req high.
imem_rvalid  in  1  response valid; at most one per request, ≥1 cycle after request.
imem_rdata  in  INS_W  instruction word, valid with imem_rvalid.
br_taken  in  1  one-cycle redirect pulse from execute.
br_target  in  PC_W  redirect address; bits [1:0] ignored (forced 0).
id_stall  in  1  decode cannot accept; id_* must hold.
id_valid  out  1  id_instr is a live instruction.
id_pc  out  PC_W  PC of id_instr.
id_instr  out  INS_W  buffered instruction.
id_opcode  out  7  id_instr[6:0]; drives the decode controller Opcode input.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC.
  - id_valid=0; id_pc=0; id_instr=32'h00000013 (NOP); id_opcode=7'b0010011; skid empty; drop_pending=0.
  - Reset mid-request discards everything; a late imem_rvalid after reset is ignored in IDLE.
- Output slot free in a cycle = !id_valid || !id_stall.
- States:
  - IDLE: next cycle -> REQ. Entered only from reset.
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_rvalid with drop_pending: discard, clear drop_pending, stay in REQ at current pc.
    - Else if slot free: load id_* with the word and id_pc=pc, id_valid=1, pc+=4, stay in REQ (new request next cycle).
    - Else: write the word and pc into the skid, pc+=4, -> HOLD.
  - HOLD: imem_req=0. When id_stall=0, move skid to id_*, empty the skid, -> REQ.
- Latency: request-to-id_valid = memory latency + 1 register stage. Back-to-back throughput is one instruction per (latency+1) cycles.
- PC arithmetic: pc+4 modulo 2^PC_W; wraps from 2^PC_W-4 to 0 silently.
- br_taken (highest priority, any state except IDLE):
  - pc=br_target&~3; id_valid=0; skid emptied; -> REQ.
  - If a request is outstanding and imem_rvalid is not present this cycle, set drop_pending=1.
  - If imem_rvalid arrives in the same cycle as br_taken, that word is discarded; drop_pending stays 0.
  - br_taken overrides id_stall: the flushed slot is invalid regardless of stall.
- id_stall with id_valid=0 has no effect: the slot is free.
- While id_stall=1 and id_valid=1, id_pc/id_instr/id_opcode are bit-stable.
- imem_addr changes only on the cycle after a response is accepted, dropped, or a redirect; it never changes while awaiting a response.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetched[31:0] and perf_flushed[31:0], both reset to 0.
  - perf_fetched increments on every word loaded into id_* or the skid.
  - perf_flushed increments on each br_taken cycle that invalidates a valid id_*/skid entry or sets drop_pending.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, 1-cycle memory (rvalid one cycle after req), no stall -> imem_addr 0,4,8,12; id_pc 0,4,8 with id_valid=1; first id_valid two cycles after the first request.
- Memory returns 32'h00A00093 at addr 0 -> id_opcode=7'b0010011, id_instr=32'h00A00093.
- id_stall held 5 cycles while a response arrives -> word goes to skid, imem_req=0, id_* unchanged. Release -> skid word appears next cycle, requests resume at the following pc.
- br_taken with br_target=9'h043 while a request to 0x10 is outstanding -> id_valid=0, response for 0x10 dropped, next accepted word has id_pc=0x040.
- pc=9'h1FC, no stall -> after fetch, imem_addr=0 (wrap).
- rst_n low for 1 cycle mid-request, then imem_rvalid pulses -> id_valid stays 0, first request after reset is to RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with a single outstanding imem request
// and an IF/ID output buffer plus a one-entry skid for decode back-pressure.
// Optional build macro FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module fetch_stage #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             id_stall,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_instr,
  output logic [6:0]       id_opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_flushed
`endif
);

  localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic              drop_pending;
  logic [PC_W-1:0]   skid_pc_p1;
  logic [INS_W-1:0]  skid_instr_p1;

  logic              slot_free;
  logic              redirect;
  logic              accept;
  logic              load_id;
  logic              load_skid;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   br_pc;

  // The output slot can take a new word if it is empty or decode is consuming it.
  assign slot_free = !id_valid || !id_stall;
  // Redirects are ignored only in IDLE, before the first request exists.
  assign redirect  = br_taken && (state != IDLE);
  // A returned word is kept only if it is not the stale reply to a redirected fetch.
  assign accept    = (state == REQ) && imem_rvalid && !drop_pending && !redirect;
  assign load_id   = (accept && slot_free) || ((state == HOLD) && !id_stall && !redirect);
  assign load_skid = accept && !slot_free;
  assign pc_inc    = pc + PC_W'(4);
  assign br_pc     = br_target & ~PC_W'(3);

  assign imem_addr = pc;
  assign id_opcode = id_instr[6:0];

  // Fetch control FSM: PC, request strobe and stale-response tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      drop_pending <= 1'b0;
      imem_req     <= 1'b0;
    end else if (redirect) begin
      state        <= REQ;
      imem_req     <= 1'b1;
      pc           <= br_pc;
      // Only an in-flight request without its reply this cycle leaves a stale word to drop.
      drop_pending <= (state == REQ) && !imem_rvalid;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_rvalid) begin
            if (drop_pending) begin
              drop_pending <= 1'b0;
            end else begin
              pc <= pc_inc;
              if (!slot_free) begin
                state    <= HOLD;
                imem_req <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (!id_stall) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID output buffer: loaded from memory or skid, cleared on consume or redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= NOP;
    end else if (redirect) begin
      id_valid <= 1'b0;
    end else if (load_id) begin
      id_valid <= 1'b1;
      id_pc    <= (state == HOLD) ? skid_pc_p1 : pc;
      id_instr <= (state == HOLD) ? skid_instr_p1 : imem_rdata;
    end else if (!id_stall) begin
      id_valid <= 1'b0;
    end
  end

  // Skid entry: occupancy is implied by the HOLD state, so only data is stored here.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_pc_p1    <= pc;
      skid_instr_p1 <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic flush_evt;
  assign flush_evt = redirect &&
                     (id_valid || (state == HOLD) || ((state == REQ) && !imem_rvalid));

  // Performance counters: words captured and redirects that discarded work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (accept)    perf_fetched <= perf_fetched + 32'd1;
      if (flush_evt) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule
